// File: rtl/peripheral_bus_arbiter.sv
// peripheral_bus_arbiter: sequences T1..T4 bus cycles toward the peripherals
// and memory, sharing the bus between the CPU port and DRAM refresh.
module peripheral_bus_arbiter #(
  parameter int io_wait_cycles     = 1,
  parameter int memory_wait_cycles = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_request,
  input  logic        cpu_io,
  input  logic        cpu_write,
  input  logic [19:0] cpu_address,
  input  logic [7:0]  cpu_write_data,
  output logic [7:0]  cpu_read_data,
  output logic        cpu_ready,
  input  logic        refresh_trigger,
  output logic        refresh_active,
  output logic        refresh_overrun,
  output logic [19:0] address,
  output logic        address_enable_n,
  input  logic [7:0]  data_bus_in,
  output logic [7:0]  data_bus_out,
  output logic        data_bus_out_enable,
  output logic        io_read_command_n,
  output logic        io_write_command_n,
  output logic        advanced_io_write_command_n,
  output logic        memory_read_command_n,
  output logic        memory_write_command_n,
  output logic        advanced_memory_write_command_n
);

  typedef enum logic [2:0] {IDLE, T1, T2, T3, T4} state_e;

  localparam logic [3:0] IoWait  = 4'(io_wait_cycles);
  localparam logic [3:0] MemWait = 4'(memory_wait_cycles);

  state_e      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic        ref_own_q, ref_own_d;
  logic        io_q, io_d;
  logic        wr_q, wr_d;
  logic [19:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [15:0] refresh_address_q, refresh_address_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        trig_q;
  logic        pend_q, pend_d;
  logic        ovr_q, ovr_d;

  logic [19:0] address_q, address_d;
  logic        aen_n_q, aen_n_d;
  logic        ref_act_q, ref_act_d;
  logic        ready_q, ready_d;
  logic [7:0]  dout_q, dout_d;
  logic        dout_en_q, dout_en_d;
  logic        ior_n_q, ior_n_d;
  logic        iow_n_q, iow_n_d;
  logic        aiow_n_q, aiow_n_d;
  logic        mr_n_q, mr_n_d;
  logic        mw_n_q, mw_n_d;
  logic        amw_n_q, amw_n_d;

  logic trig_rise;
  logic ref_req;
  logic acc_ref;

  assign trig_rise = refresh_trigger & ~trig_q;
  assign ref_req   = pend_q | trig_rise;
  assign acc_ref   = (state_q == IDLE) & ref_req;

  // Refresh bookkeeping: an edge consumed by acceptance does not stay pending.
  always_comb begin
    pend_d = pend_q | trig_rise;
    ovr_d  = ovr_q | (trig_rise & pend_q);
    if (acc_ref) begin
      pend_d = pend_q & trig_rise;
    end
  end

  // Next state, transfer latch, wait counter and read-data capture.
  always_comb begin
    state_d           = state_q;
    wait_d            = wait_q;
    ref_own_d         = ref_own_q;
    io_d              = io_q;
    wr_d              = wr_q;
    addr_d            = addr_q;
    wdata_d           = wdata_q;
    refresh_address_d = refresh_address_q;
    rdata_d           = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (ref_req) begin
          state_d   = T1;
          ref_own_d = 1'b1;
          io_d      = 1'b0;
          wr_d      = 1'b0;
          addr_d    = {4'h0, refresh_address_q};
          wdata_d   = 8'h00;
        end else if (cpu_request) begin
          state_d   = T1;
          ref_own_d = 1'b0;
          io_d      = cpu_io;
          wr_d      = cpu_write;
          addr_d    = cpu_address;
          wdata_d   = cpu_write_data;
        end
      end
      T1: state_d = T2;
      T2: begin
        state_d = T3;
        wait_d  = io_q ? IoWait : MemWait;
      end
      T3: begin
        if (wait_q == 4'd0) begin
          state_d = T4;
          if (!ref_own_q && !wr_q) begin
            rdata_d = data_bus_in;
          end
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      T4: begin
        state_d = IDLE;
        if (ref_own_q) begin
          refresh_address_d = refresh_address_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered bus outputs derived from the state being entered.
  always_comb begin
    logic busy;
    logic strb;
    logic t3;
    busy      = (state_d != IDLE);
    strb      = (state_d == T2) || (state_d == T3);
    t3        = (state_d == T3);
    address_d = busy ? addr_d : 20'h0;
    aen_n_d   = busy & ~ref_own_d;
    ref_act_d = busy & ref_own_d;
    ready_d   = (state_d == T4) & ~ref_own_d;
    dout_en_d = busy & wr_d;
    dout_d    = dout_en_d ? wdata_d : 8'h00;
    ior_n_d   = ~(strb & ~wr_d & io_d);
    aiow_n_d  = ~(strb & wr_d & io_d);
    iow_n_d   = ~(t3 & wr_d & io_d);
    mr_n_d    = ~(strb & ~wr_d & ~io_d);
    amw_n_d   = ~(strb & wr_d & ~io_d);
    mw_n_d    = ~(t3 & wr_d & ~io_d);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    trig_q <= refresh_trigger;
    if (reset) begin
      state_q           <= IDLE;
      wait_q            <= 4'd0;
      ref_own_q         <= 1'b0;
      io_q              <= 1'b0;
      wr_q              <= 1'b0;
      addr_q            <= 20'h0;
      wdata_q           <= 8'h00;
      refresh_address_q <= 16'h0000;
      rdata_q           <= 8'h00;
      pend_q            <= 1'b0;
      ovr_q             <= 1'b0;
      address_q         <= 20'h0;
      aen_n_q           <= 1'b0;
      ref_act_q         <= 1'b0;
      ready_q           <= 1'b0;
      dout_q            <= 8'h00;
      dout_en_q         <= 1'b0;
      ior_n_q           <= 1'b1;
      iow_n_q           <= 1'b1;
      aiow_n_q          <= 1'b1;
      mr_n_q            <= 1'b1;
      mw_n_q            <= 1'b1;
      amw_n_q           <= 1'b1;
    end else begin
      state_q           <= state_d;
      wait_q            <= wait_d;
      ref_own_q         <= ref_own_d;
      io_q              <= io_d;
      wr_q              <= wr_d;
      addr_q            <= addr_d;
      wdata_q           <= wdata_d;
      refresh_address_q <= refresh_address_d;
      rdata_q           <= rdata_d;
      pend_q            <= pend_d;
      ovr_q             <= ovr_d;
      address_q         <= address_d;
      aen_n_q           <= aen_n_d;
      ref_act_q         <= ref_act_d;
      ready_q           <= ready_d;
      dout_q            <= dout_d;
      dout_en_q         <= dout_en_d;
      ior_n_q           <= ior_n_d;
      iow_n_q           <= iow_n_d;
      aiow_n_q          <= aiow_n_d;
      mr_n_q            <= mr_n_d;
      mw_n_q            <= mw_n_d;
      amw_n_q           <= amw_n_d;
    end
  end

  assign cpu_read_data                   = rdata_q;
  assign cpu_ready                       = ready_q;
  assign refresh_active                  = ref_act_q;
  assign refresh_overrun                 = ovr_q;
  assign address                         = address_q;
  assign address_enable_n                = aen_n_q;
  assign data_bus_out                    = dout_q;
  assign data_bus_out_enable             = dout_en_q;
  assign io_read_command_n               = ior_n_q;
  assign io_write_command_n              = iow_n_q;
  assign advanced_io_write_command_n     = aiow_n_q;
  assign memory_read_command_n           = mr_n_q;
  assign memory_write_command_n          = mw_n_q;
  assign advanced_memory_write_command_n = amw_n_q;

endmodule

// File: tb/tb_peripheral_bus_arbiter.sv
// tb_peripheral_bus_arbiter: directed tables, corner sequences and random
// traffic against a transaction-level timing model.
module tb_peripheral_bus_arbiter;

  localparam int IOW  = 1;
  localparam int MEMW = 0;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_request, cpu_io, cpu_write;
  logic [19:0] cpu_address;
  logic [7:0]  cpu_write_data;
  logic [7:0]  cpu_read_data;
  logic        cpu_ready;
  logic        refresh_trigger;
  logic        refresh_active, refresh_overrun;
  logic [19:0] address;
  logic        address_enable_n;
  logic [7:0]  data_bus_in, data_bus_out;
  logic        data_bus_out_enable;
  logic        io_read_command_n, io_write_command_n;
  logic        advanced_io_write_command_n;
  logic        memory_read_command_n, memory_write_command_n;
  logic        advanced_memory_write_command_n;

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;

  always #5 clock = ~clock;

  peripheral_bus_arbiter #(
    .io_wait_cycles(IOW),
    .memory_wait_cycles(MEMW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .cpu_request(cpu_request),
    .cpu_io(cpu_io),
    .cpu_write(cpu_write),
    .cpu_address(cpu_address),
    .cpu_write_data(cpu_write_data),
    .cpu_read_data(cpu_read_data),
    .cpu_ready(cpu_ready),
    .refresh_trigger(refresh_trigger),
    .refresh_active(refresh_active),
    .refresh_overrun(refresh_overrun),
    .address(address),
    .address_enable_n(address_enable_n),
    .data_bus_in(data_bus_in),
    .data_bus_out(data_bus_out),
    .data_bus_out_enable(data_bus_out_enable),
    .io_read_command_n(io_read_command_n),
    .io_write_command_n(io_write_command_n),
    .advanced_io_write_command_n(advanced_io_write_command_n),
    .memory_read_command_n(memory_read_command_n),
    .memory_write_command_n(memory_write_command_n),
    .advanced_memory_write_command_n(advanced_memory_write_command_n)
  );

  task automatic cmp(string nm, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] span(int lo, int hi);
    logic [63:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Model: k is the cycle index inside the running transfer (0 = idle).
  int          k = 0;
  int          m_w = 0;
  bit          m_ref, m_io, m_wr;
  logic [19:0] m_addr;
  logic [7:0]  m_data;
  logic [7:0]  m_rdata = 8'h00;
  logic [15:0] m_raddr = 16'h0000;
  bit          m_pend = 1'b0, m_prev = 1'b0, m_ovr = 1'b0;

  always @(posedge clock) begin
    bit e, op;
    e = refresh_trigger && !m_prev;
    m_prev = refresh_trigger;
    if (reset) begin
      k = 0; m_pend = 0; m_ovr = 0; m_raddr = 0; m_rdata = 0;
      m_ref = 0; m_wr = 0; m_io = 0;
    end else begin
      op = m_pend;
      if (e && op) m_ovr = 1;
      if (k == 0) begin
        if (op || e) begin
          m_ref = 1; m_io = 0; m_wr = 0; m_data = 0;
          m_addr = {4'h0, m_raddr}; m_w = MEMW; k = 1;
          m_pend = op && e;
        end else begin
          m_pend = op || e;
          if (cpu_request) begin
            m_ref = 0; m_io = cpu_io; m_wr = cpu_write;
            m_addr = cpu_address; m_data = cpu_write_data;
            m_w = cpu_io ? IOW : MEMW; k = 1;
          end
        end
      end else begin
        m_pend = op || e;
        if (k == 3 + m_w && !m_ref && !m_wr) m_rdata = data_bus_in;
        if (k == 4 + m_w) begin
          if (m_ref) m_raddr = m_raddr + 16'd1;
          k = 0;
        end else begin
          k++;
        end
      end
    end
  end

  // Per-cycle scoreboard of every output against the model.
  always @(negedge clock) begin
    if (chk_on) begin
      bit busy, strb, t3;
      busy = (k > 0);
      strb = busy && k >= 2 && k <= 3 + m_w;
      t3   = busy && k >= 3 && k <= 3 + m_w;
      cmp("address", address, busy ? m_addr : 20'h0);
      cmp("aen_n", address_enable_n, busy && !m_ref);
      cmp("ref_active", refresh_active, busy && m_ref);
      cmp("ready", cpu_ready, busy && !m_ref && k == 4 + m_w);
      cmp("oe", data_bus_out_enable, busy && m_wr);
      cmp("dout", data_bus_out, (busy && m_wr) ? m_data : 8'h00);
      cmp("ior_n", io_read_command_n, !(strb && !m_wr && m_io));
      cmp("aiow_n", advanced_io_write_command_n, !(strb && m_wr && m_io));
      cmp("iow_n", io_write_command_n, !(t3 && m_wr && m_io));
      cmp("mr_n", memory_read_command_n, !(strb && !m_wr && !m_io));
      cmp("amw_n", advanced_memory_write_command_n, !(strb && m_wr && !m_io));
      cmp("mw_n", memory_write_command_n, !(t3 && m_wr && !m_io));
      cmp("rdata", cpu_read_data, m_rdata);
      cmp("overrun", refresh_overrun, m_ovr);
    end
  end

  typedef struct {
    bit          io;
    bit          wr;
    logic [19:0] a;
    logic [7:0]  wd;
    logic [7:0]  din;
    int          len;
    logic [7:0]  rd;
  } vec_t;

  vec_t tbl[7];

  task automatic run_cpu(input bit trig, input bit io, input bit wr,
                         input logic [19:0] a, input logic [7:0] wd,
                         input logic [7:0] din, output int len,
                         output logic [7:0] rd, output logic [63:0] rm,
                         output logic [63:0] awm, output logic [63:0] wm,
                         output logic [63:0] aenm, output logic [63:0] refm,
                         output logic [63:0] oem);
    @(negedge clock);
    cpu_request = 1; cpu_io = io; cpu_write = wr;
    cpu_address = a; cpu_write_data = wd;
    data_bus_in = din; refresh_trigger = trig;
    len = 0; rd = 8'hxx;
    rm = 0; awm = 0; wm = 0; aenm = 0; refm = 0; oem = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (!io_read_command_n || !memory_read_command_n) rm[n] = 1;
      if (!advanced_io_write_command_n || !advanced_memory_write_command_n)
        awm[n] = 1;
      if (!io_write_command_n || !memory_write_command_n) wm[n] = 1;
      if (address_enable_n) aenm[n] = 1;
      if (refresh_active) refm[n] = 1;
      if (data_bus_out_enable) oem[n] = 1;
      if (cpu_ready) begin
        len = n;
        rd = cpu_read_data;
        break;
      end
    end
    cpu_request = 0;
  endtask

  task automatic do_refresh(output logic [19:0] a);
    a = 20'hxxxxx;
    @(negedge clock);
    refresh_trigger = 1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      if (refresh_active) begin
        a = address;
        break;
      end
    end
    for (int n = 0; n < 20; n++) begin
      if (!refresh_active) break;
      @(negedge clock);
    end
    refresh_trigger = 0;
  endtask

  initial begin
    int          len;
    logic [7:0]  rd;
    logic [63:0] rm, awm, wm, aenm, refm, oem;
    logic [19:0] ra;
    int          w;
    int          cnt;

    tbl[0] = '{1, 0, 20'h00060, 8'h00, 8'hA5, 5, 8'hA5};
    tbl[1] = '{0, 1, 20'hB8000, 8'h41, 8'h00, 4, 8'hA5};
    tbl[2] = '{0, 0, 20'h12345, 8'h00, 8'h3C, 4, 8'h3C};
    tbl[3] = '{1, 1, 20'h003F8, 8'h7E, 8'h11, 5, 8'h3C};
    tbl[4] = '{1, 0, 20'h00021, 8'h00, 8'h81, 5, 8'h81};
    tbl[5] = '{0, 0, 20'hFFFFF, 8'h00, 8'hFF, 4, 8'hFF};
    tbl[6] = '{0, 1, 20'h00000, 8'h00, 8'h22, 4, 8'hFF};

    reset = 1; cpu_request = 0; cpu_io = 0; cpu_write = 0;
    cpu_address = 0; cpu_write_data = 0; refresh_trigger = 0;
    data_bus_in = 0;
    repeat (2) @(negedge clock);
    chk_on = 1;
    cmp("rst_strobes", {io_read_command_n, io_write_command_n,
        advanced_io_write_command_n, memory_read_command_n,
        memory_write_command_n, advanced_memory_write_command_n}, 6'h3F);
    cmp("rst_address", address, 20'h0);
    cmp("rst_aen_n", address_enable_n, 1'b0);
    cmp("rst_rdata", cpu_read_data, 8'h00);
    reset = 0;

    for (int i = 0; i < 7; i++) begin
      run_cpu(0, tbl[i].io, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].din,
              len, rd, rm, awm, wm, aenm, refm, oem);
      w = tbl[i].io ? IOW : MEMW;
      cmp($sformatf("tbl%0d_len", i), len, tbl[i].len);
      cmp($sformatf("tbl%0d_rdata", i), rd, tbl[i].rd);
      cmp($sformatf("tbl%0d_rd_win", i), rm, tbl[i].wr ? 0 : span(2, 3 + w));
      cmp($sformatf("tbl%0d_aw_win", i), awm, tbl[i].wr ? span(2, 3 + w) : 0);
      cmp($sformatf("tbl%0d_w_win", i), wm, tbl[i].wr ? span(3, 3 + w) : 0);
      cmp($sformatf("tbl%0d_aen_win", i), aenm, span(1, 4 + w));
      cmp($sformatf("tbl%0d_oe_win", i), oem, tbl[i].wr ? span(1, 4 + w) : 0);
    end

    // Refresh edge and CPU request in the same idle clock.
    run_cpu(1, 0, 0, 20'h00400, 8'h00, 8'h5A,
            len, rd, rm, awm, wm, aenm, refm, oem);
    cmp("prio_len", len, 9);
    cmp("prio_ref_win", refm, span(1, 4));
    cmp("prio_aen_win", aenm, span(6, 9));
    cmp("prio_rdata", rd, 8'h5A);

    // Refresh address wrap from FFFF.
    @(negedge clock);
    refresh_trigger = 0;
    force dut.refresh_address_q = 16'hFFFF;
    m_raddr = 16'hFFFF;
    repeat (2) @(negedge clock);
    release dut.refresh_address_q;
    do_refresh(ra);
    cmp("wrap_ffff", ra, 20'h0FFFF);
    do_refresh(ra);
    cmp("wrap_0000", ra, 20'h00000);

    // Two trigger edges during one CPU cycle.
    cmp("ovr_before", refresh_overrun, 1'b0);
    @(negedge clock);
    cpu_request = 1; cpu_io = 1; cpu_write = 0; cpu_address = 20'h00040;
    cnt = 0;
    while (!address_enable_n && cnt < 10) begin
      @(negedge clock);
      cnt++;
    end
    cmp("ovr_start", address_enable_n, 1'b1);
    @(negedge clock) refresh_trigger = 1;
    @(negedge clock) refresh_trigger = 0;
    @(negedge clock) refresh_trigger = 1;
    cnt = 0;
    while (!cpu_ready && cnt < 20) begin
      @(negedge clock);
      cnt++;
    end
    cmp("ovr_ready", cpu_ready, 1'b1);
    cpu_request = 0;
    repeat (15) @(negedge clock);
    cmp("ovr_set", refresh_overrun, 1'b1);
    repeat (10) @(negedge clock);
    cmp("ovr_sticky", refresh_overrun, 1'b1);

    // Reset during T3 of an I/O write.
    refresh_trigger = 0;
    cpu_request = 1; cpu_io = 1; cpu_write = 1;
    cpu_address = 20'h00080; cpu_write_data = 8'h99;
    cnt = 0;
    while (io_write_command_n && cnt < 20) begin
      @(negedge clock);
      cnt++;
    end
    cmp("rst_t3_reached", io_write_command_n, 1'b0);
    reset = 1;
    @(negedge clock);
    cmp("rst_t3_strobes", {io_read_command_n, io_write_command_n,
        advanced_io_write_command_n, memory_read_command_n,
        memory_write_command_n, advanced_memory_write_command_n}, 6'h3F);
    cmp("rst_t3_ready", cpu_ready, 1'b0);
    cmp("rst_t3_aen_n", address_enable_n, 1'b0);
    cmp("rst_t3_ovr", refresh_overrun, 1'b0);
    reset = 0; cpu_request = 0;
    cnt = 0;
    repeat (10) begin
      @(negedge clock);
      if (cpu_ready) cnt++;
    end
    cmp("rst_t3_no_ready", cnt, 0);
    do_refresh(ra);
    cmp("rst_raddr", ra, 20'h00000);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      if (!cpu_request || cpu_ready)
        cpu_request = ($urandom_range(0, 3) != 0);
      else if ($urandom_range(0, 40) == 0)
        cpu_request = 0;
      cpu_io = $urandom_range(0, 1);
      cpu_write = $urandom_range(0, 1);
      cpu_address = 20'($urandom);
      cpu_write_data = 8'($urandom);
      data_bus_in = 8'($urandom);
      if ($urandom_range(0, 12) == 0) refresh_trigger = ~refresh_trigger;
      reset = ($urandom_range(0, 600) == 0);
    end
    @(negedge clock);
    reset = 0; cpu_request = 0;
    repeat (10) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
